// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the fetch stage: state encoding, opcode width and the NOP word.
package unidade_busca_pkg;

    localparam int OPCODE_W = 6;
    localparam logic [OPCODE_W-1:0] OPCODE_NOP = 6'b101000;
    localparam logic [31:0] NOP = {OPCODE_NOP, {(32-OPCODE_W){1'b0}}};

    typedef enum logic [1:0] {
        EXECUTA = 2'd0,
        INJETA  = 2'd1,
        PARADO  = 2'd2
    } estado_t;

endpackage

// File: rtl/unidade_busca_if.sv
// Signal bundle between the fetch stage and its neighbours (timer, memory, execute, control).
// No valid/ready handshake: every input is sampled on each rising clk edge and every output is valid every cycle.
interface unidade_busca_if;
    import unidade_busca_pkg::*;

    logic        flag_pausa;
    logic [31:0] saida_instrucao;
    logic [31:0] mem_dado;
    logic        desvio;
    logic [31:0] end_desvio;
    logic        halt;
    logic        continuar;
    logic [31:0] end_pc;
    logic [31:0] instrucao;
    logic [31:0] pc_salvo;
    logic        em_pausa;
    logic        parado;
    estado_t     estado;

    // master = the fetch stage itself; slave = the surrounding pipeline
    modport master (
        input  flag_pausa, saida_instrucao, mem_dado, desvio, end_desvio, halt, continuar,
        output end_pc, instrucao, pc_salvo, em_pausa, parado, estado
    );

    modport slave (
        output flag_pausa, saida_instrucao, mem_dado, desvio, end_desvio, halt, continuar,
        input  end_pc, instrucao, pc_salvo, em_pausa, parado, estado
    );

endinterface

// File: rtl/unidade_busca_seletor_retomada.sv
// Holds the preempted PC and the first branch target seen during a pause; yields the resume address.
module unidade_busca_seletor_retomada (
    input  logic        clk,
    input  logic        reset,
    input  logic        captura_i,
    input  logic [31:0] pc_atual_i,
    input  logic        desvio_i,
    input  logic [31:0] end_desvio_i,
    output logic [31:0] pc_salvo_o,
    output logic [31:0] retomada_o
);
    logic [31:0] pc_salvo_q, pc_salvo_d;
    logic [31:0] destino_q, destino_d;
    logic        tem_destino_q, tem_destino_d;

    always_comb begin
        pc_salvo_d    = pc_salvo_q;
        destino_d     = destino_q;
        tem_destino_d = tem_destino_q;
        if (captura_i) begin
            pc_salvo_d    = pc_atual_i;
            tem_destino_d = 1'b0;
        end else if (desvio_i && !tem_destino_q) begin
            // only the first branch of a pause counts; later ones are stale re-issues
            destino_d     = end_desvio_i;
            tem_destino_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_salvo_q    <= 32'd0;
            destino_q     <= 32'd0;
            tem_destino_q <= 1'b0;
        end else begin
            pc_salvo_q    <= pc_salvo_d;
            destino_q     <= destino_d;
            tem_destino_q <= tem_destino_d;
        end
    end

    assign pc_salvo_o = pc_salvo_q;
    assign retomada_o = tem_destino_q ? destino_q : pc_salvo_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: PC ownership, pause/halt sequencing and instruction selection for decode.
// Optional feature: define UNIDADE_BUSCA_CONTADOR_EN to add the instr_contadas fetch counter.
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter logic [31:0] PC_INICIAL = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef UNIDADE_BUSCA_CONTADOR_EN
    output logic [31:0] instr_contadas,
`endif
    unidade_busca_if.master bus
);
    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic        captura;
    logic        desvio_inj;
    logic [31:0] retomada;

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        captura  = 1'b0;
        case (estado_q)
            EXECUTA: begin
                if (bus.halt) begin
                    estado_d = PARADO;
                end else if (bus.flag_pausa) begin
                    // pause beats a same-cycle branch; execute re-issues it after resume
                    estado_d = INJETA;
                    captura  = 1'b1;
                end else if (bus.desvio) begin
                    pc_d = bus.end_desvio;
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end
            INJETA: begin
                if (!bus.flag_pausa) begin
                    estado_d = EXECUTA;
                    pc_d     = retomada;
                end
            end
            PARADO: begin
                if (bus.continuar) begin
                    estado_d = EXECUTA;
                    pc_d     = pc_q + 32'd1;
                end
            end
            default: estado_d = EXECUTA;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= EXECUTA;
            pc_q     <= PC_INICIAL;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
        end
    end

    assign desvio_inj = (estado_q == INJETA) && bus.flag_pausa && bus.desvio;

    unidade_busca_seletor_retomada u_seletor_retomada (
        .clk          (clk),
        .reset        (reset),
        .captura_i    (captura),
        .pc_atual_i   (pc_q),
        .desvio_i     (desvio_inj),
        .end_desvio_i (bus.end_desvio),
        .pc_salvo_o   (bus.pc_salvo),
        .retomada_o   (retomada)
    );

    always_comb begin
        case (estado_q)
            INJETA:  bus.instrucao = bus.saida_instrucao;
            PARADO:  bus.instrucao = NOP;
            default: bus.instrucao = bus.mem_dado;
        endcase
    end

    assign bus.end_pc   = pc_q;
    assign bus.em_pausa = (estado_q == INJETA);
    assign bus.parado   = (estado_q == PARADO);
    assign bus.estado   = estado_q;

`ifdef UNIDADE_BUSCA_CONTADOR_EN
    logic [31:0] contador_q, contador_d;

    always_comb begin
        contador_d = contador_q;
        if (captura) begin
            contador_d = 32'd0;
        end else if (estado_q == EXECUTA && !bus.halt && !bus.flag_pausa) begin
            contador_d = contador_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contador_q <= 32'd0;
        end else begin
            contador_q <= contador_d;
        end
    end

    assign instr_contadas = contador_q;
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca against a cycle-level behavioural model of the fetch rules.
module tb_unidade_busca;

    localparam logic [31:0] PC_INI  = 32'h10;
    localparam logic [31:0] NOP_EXP = {6'b101000, 26'd0};

    logic clk = 1'b0;
    logic reset;
`ifdef UNIDADE_BUSCA_CONTADOR_EN
    logic [31:0] instr_contadas;
`endif

    unidade_busca_if bus ();

    unidade_busca #(.PC_INICIAL(PC_INI)) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef UNIDADE_BUSCA_CONTADOR_EN
        .instr_contadas (instr_contadas),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // instruction memory: fixed scrambling of the address
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.mem_dado = mem_fn(bus.end_pc);

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    logic [31:0] m_pc, m_salvo, m_cnt;
    bit          m_pausa, m_parado;
    logic [31:0] dest_q[$];

    function automatic logic [31:0] exp_instr();
        if (m_parado) return NOP_EXP;
        if (m_pausa)  return bus.saida_instrucao;
        return mem_fn(m_pc);
    endfunction

    task automatic model_reset();
        m_pc = PC_INI; m_salvo = 32'd0; m_cnt = 32'd0;
        m_pausa = 1'b0; m_parado = 1'b0;
        dest_q.delete();
    endtask

    task automatic model_edge(input bit f, input bit d, input logic [31:0] ed, input bit h, input bit c);
        if (m_parado) begin
            if (c) begin m_parado = 1'b0; m_pc = m_pc + 32'd1; end
        end else if (m_pausa) begin
            if (!f) begin
                m_pc    = (dest_q.size() > 0) ? dest_q[0] : m_salvo;
                m_pausa = 1'b0;
            end else if (d) begin
                dest_q.push_back(ed);
            end
        end else begin
            if (h) m_parado = 1'b1;
            else if (f) begin
                m_pausa = 1'b1; m_salvo = m_pc; m_cnt = 32'd0; dest_q.delete();
            end else begin
                m_cnt = m_cnt + 32'd1;
                m_pc  = d ? ed : m_pc + 32'd1;
            end
        end
    endtask

    // drive one cycle of inputs, clock it, advance the model, settle 1 time unit past the edge
    task automatic step(input bit f, input bit d, input logic [31:0] ed, input bit h, input bit c);
        bus.flag_pausa      = f;
        bus.desvio          = d;
        bus.end_desvio      = ed;
        bus.halt            = h;
        bus.continuar       = c;
        bus.saida_instrucao = $urandom;
        @(posedge clk);
        model_edge(f, d, ed, h, c);
        #1;
    endtask

    task automatic do_reset();
        bus.flag_pausa = 1'b0; bus.desvio = 1'b0; bus.end_desvio = 32'd0;
        bus.halt = 1'b0; bus.continuar = 1'b0; bus.saida_instrucao = 32'hDEAD_BEEF;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.end_pc !== 32'h10) begin n_fail++; $display("FAIL reset_end_pc got=%h exp=%h", bus.end_pc, 32'h10); end
        n_checks++;
        if (bus.pc_salvo !== 32'd0 || bus.em_pausa !== 1'b0 || bus.parado !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got salvo=%h pausa=%b parado=%b exp 0/0/0", bus.pc_salvo, bus.em_pausa, bus.parado);
        end
        n_checks++;
        if (bus.instrucao !== mem_fn(32'h10)) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", bus.instrucao, mem_fn(32'h10)); end
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (bus.end_pc !== 32'h10 + i) begin n_fail++; $display("FAIL idle_end_pc got=%h exp=%h", bus.end_pc, 32'h10 + i); end
            n_checks++;
            if (bus.instrucao !== mem_fn(32'h10 + i)) begin n_fail++; $display("FAIL idle_instr got=%h exp=%h", bus.instrucao, mem_fn(32'h10 + i)); end
        end
    endtask

    task automatic test_pausa();
        step(0, 1, 32'h20, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0);
            n_checks++;
            if (bus.end_pc !== 32'h20 || bus.pc_salvo !== 32'h20 || bus.em_pausa !== 1'b1) begin
                n_fail++; $display("FAIL pausa_hold got pc=%h salvo=%h pausa=%b exp 20/20/1", bus.end_pc, bus.pc_salvo, bus.em_pausa);
            end
            n_checks++;
            if (bus.instrucao !== bus.saida_instrucao) begin n_fail++; $display("FAIL pausa_instr got=%h exp=%h", bus.instrucao, bus.saida_instrucao); end
        end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (bus.end_pc !== 32'h20 || bus.em_pausa !== 1'b0) begin
            n_fail++; $display("FAIL pausa_resume got pc=%h pausa=%b exp 20/0", bus.end_pc, bus.em_pausa);
        end
    endtask

    task automatic test_desvio_pausa();
        step(1, 0, 0, 0, 0);
        step(1, 1, 32'h151, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 32'h99, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (bus.end_pc !== 32'h151) begin n_fail++; $display("FAIL desvio_pausa_resume got=%h exp=%h", bus.end_pc, 32'h151); end
    endtask

    task automatic test_simultaneo();
        step(0, 1, 32'h30, 0, 0);
        step(1, 1, 32'h40, 0, 0);
        n_checks++;
        if (bus.em_pausa !== 1'b1 || bus.pc_salvo !== 32'h30 || bus.end_pc !== 32'h30) begin
            n_fail++; $display("FAIL simult_entry got pausa=%b salvo=%h pc=%h exp 1/30/30", bus.em_pausa, bus.pc_salvo, bus.end_pc);
        end
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (bus.end_pc !== 32'h30) begin n_fail++; $display("FAIL simult_resume got=%h exp=%h", bus.end_pc, 32'h30); end
    endtask

    task automatic test_halt();
        step(0, 1, 32'h08, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step((i % 2) == 0, 0, 0, 1, 0);
            n_checks++;
            if (bus.instrucao !== NOP_EXP || bus.em_pausa !== 1'b0 || bus.parado !== 1'b1 || bus.end_pc !== 32'h08) begin
                n_fail++; $display("FAIL halt_hold got instr=%h pausa=%b parado=%b pc=%h exp %h/0/1/08",
                                   bus.instrucao, bus.em_pausa, bus.parado, bus.end_pc, NOP_EXP);
            end
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (bus.end_pc !== 32'h09 || bus.parado !== 1'b0) begin
            n_fail++; $display("FAIL halt_continuar got pc=%h parado=%b exp 09/0", bus.end_pc, bus.parado);
        end
    endtask

    task automatic test_wrap_reset();
        step(0, 1, 32'hFFFF_FFFF, 0, 0);
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (bus.end_pc !== 32'h0) begin n_fail++; $display("FAIL wrap got=%h exp=%h", bus.end_pc, 32'h0); end
        step(1, 0, 0, 0, 0);
        step(1, 1, 32'h777, 0, 0);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.em_pausa !== 1'b0 || bus.end_pc !== PC_INI || bus.pc_salvo !== 32'd0) begin
            n_fail++; $display("FAIL async_reset got pausa=%b pc=%h salvo=%h exp 0/%h/0", bus.em_pausa, bus.end_pc, bus.pc_salvo, PC_INI);
        end
        bus.flag_pausa = 1'b0; bus.desvio = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (bus.end_pc !== PC_INI + 32'd1) begin n_fail++; $display("FAIL post_reset got=%h exp=%h", bus.end_pc, PC_INI + 32'd1); end
    endtask

    task automatic test_random();
        bit f, d, h, c;
        logic [31:0] ed;
        for (int i = 0; i < 400; i++) begin
            f  = m_pausa ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0);
            d  = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 19) == 0);
            c  = ($urandom_range(0, 2) == 0);
            ed = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2) : $urandom;
            step(f, d, ed, h, c);
            n_checks++;
            if (bus.end_pc !== m_pc) begin n_fail++; $display("FAIL rand_end_pc cyc=%0d got=%h exp=%h", i, bus.end_pc, m_pc); end
            n_checks++;
            if (bus.pc_salvo !== m_salvo) begin n_fail++; $display("FAIL rand_pc_salvo cyc=%0d got=%h exp=%h", i, bus.pc_salvo, m_salvo); end
            n_checks++;
            if (bus.em_pausa !== m_pausa || bus.parado !== m_parado) begin
                n_fail++; $display("FAIL rand_state cyc=%0d got pausa=%b parado=%b exp %b/%b", i, bus.em_pausa, bus.parado, m_pausa, m_parado);
            end
            n_checks++;
            if (bus.instrucao !== exp_instr()) begin n_fail++; $display("FAIL rand_instr cyc=%0d got=%h exp=%h", i, bus.instrucao, exp_instr()); end
`ifdef UNIDADE_BUSCA_CONTADOR_EN
            n_checks++;
            if (instr_contadas !== m_cnt) begin n_fail++; $display("FAIL rand_contador cyc=%0d got=%0d exp=%0d", i, instr_contadas, m_cnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_pausa();
        test_desvio_pausa();
        test_simultaneo();
        test_halt();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
